// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response port between the load/store unit and memory.
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH/8
);
   logic                  req;
   logic                  we;
   logic [DATA_WIDTH-1:0] addr;
   logic [BE_WIDTH-1:0]   be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte-enable/lane replication on stores, sign/zero
// extension on loads, pipeline stall until the memory access completes.
module lsu_lane #(
   parameter int LANE = 0
) (
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic        be,
   output logic [7:0]  lbyte
);
   localparam logic [1:0] LIDX = 2'(LANE);
   localparam logic       HALF = (LANE >= 2);

   always_comb begin
      be    = 1'b1;
      lbyte = word[8*LANE +: 8];
      case (size)
         2'b00: begin
            be    = (off == LIDX);
            lbyte = word[7:0];
         end
         2'b01: begin
            be    = (off[1] == HALF);
            lbyte = word[8*(LANE%2) +: 8];
         end
         default: ;
      endcase
   end
endmodule

module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  we_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic                  misalign_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   load_store_unit_if.master     mem
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   typedef struct packed {
      logic                  we;
      logic [2:0]            f3;
      logic [DATA_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } lsu_req_t;

   state_t   state, state_nxt;
   lsu_req_t lat;
   logic     ok, accept, req;
   logic [DATA_WIDTH-1:0]      ext;
   logic [BE_WIDTH-1:0]        be_l;
   logic [BE_WIDTH-1:0][7:0]   wd_l;
   logic [7:0]                 bsel;
   logic [15:0]                hsel;

   always_comb begin
      ok = 1'b0;
      case (funct3_i)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = ~addr_i[0];
         3'b010:         ok = (addr_i[1:0] == 2'b00);
         default:        ok = 1'b0;
      endcase
   end

   // misalign/stall are forced low while rst is held so upstream never sees a stale request
   assign accept     = ~rst & (state == IDLE) & valid_i & ok;
   assign misalign_o = ~rst & (state == IDLE) & valid_i & ~ok;
   assign stall_o    = accept | (~rst & ((state == REQ) | (state == WAIT)));
   assign done_o     = (state == DONE);
   assign req        = (state == REQ);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = REQ;
         REQ:  if (mem.gnt) state_nxt = lat.we ? DONE : WAIT;
         WAIT: if (mem.rvalid) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         lat     <= '0;
         rdata_o <= '0;
      end else begin
         state <= state_nxt;
         if (accept) lat <= '{we: we_i, f3: funct3_i, addr: addr_i, wdata: wdata_i};
         if (state == WAIT && mem.rvalid) rdata_o <= ext;
      end
   end

   for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
      lsu_lane #(.LANE(i)) u_lane (
         .size  (lat.f3[1:0]),
         .off   (lat.addr[1:0]),
         .word  (lat.wdata),
         .be    (be_l[i]),
         .lbyte (wd_l[i])
      );
   end

   always_comb begin
      mem.req   = req;
      mem.we    = req & lat.we;
      mem.addr  = req ? {lat.addr[DATA_WIDTH-1:2], 2'b00} : '0;
      mem.be    = req ? be_l : '0;
      mem.wdata = req ? wd_l : '0;
   end

   always_comb begin
      bsel = mem.rdata[8*lat.addr[1:0] +: 8];
      hsel = lat.addr[1] ? mem.rdata[31:16] : mem.rdata[15:0];
      case (lat.f3)
         3'b000:  ext = {{24{bsel[7]}}, bsel};
         3'b001:  ext = {{16{hsel[15]}}, hsel};
         3'b100:  ext = {24'd0, bsel};
         3'b101:  ext = {16'd0, hsel};
         default: ext = mem.rdata;
      endcase
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic        we_i = 1'b0;
   logic [2:0]  funct3_i = 3'd0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        stall_o, done_o, misalign_o;
   logic [31:0] rdata_o;
   logic [31:0] model_rd = '0;
   int          checks = 0;
   int          errors = 0;

   load_store_unit_if #(.DATA_WIDTH(32)) mif ();

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .we_i       (we_i),
      .funct3_i   (funct3_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .misalign_o (misalign_o),
      .rdata_o    (rdata_o),
      .mem        (mif.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      return (a % m_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int n = m_size(f3);
      int off = a % 4;
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n = m_size(f3);
      for (int j = 0; j < 4; j++) r[8*j +: 8] = wd[8*(j % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      longint one = 1;
      int n = m_size(f3);
      int off = a % 4;
      longint v = (longint'(word) >> (8*off)) & ((one << (8*n)) - 1);
      if (f3[2] == 1'b0 && n < 4 && v >= (one << (8*n - 1))) v = v - (one << (8*n));
      return v[31:0];
   endfunction

   task automatic scramble();
      valid_i  = 1'($urandom);
      we_i     = 1'($urandom);
      funct3_i = 3'($urandom);
      addr_i   = $urandom;
      wdata_i  = $urandom;
   endtask

   // one instruction: gd = cycles gnt is held low, rd = WAIT cycles before rvalid
   task automatic access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rd, input logic [31:0] word);
      bit legal;
      int stalls;
      @(posedge clk); #1;
      valid_i = 1'b1; we_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
      mif.gnt = 1'b0; mif.rvalid = 1'b0;
      legal = m_legal(f3, a);
      @(negedge clk);
      chk("misalign", misalign_o, legal ? 0 : 1);
      chk("stall_acc", stall_o, legal ? 1 : 0);
      chk("req_idle", mif.req, 0);
      if (!legal) begin
         @(posedge clk); #1;
         valid_i = 1'b0;
         @(negedge clk);
         chk("req_after_mis", mif.req, 0);
         chk("stall_after_mis", stall_o, 0);
         return;
      end
      stalls = 1;
      for (int k = 0; k <= gd; k++) begin
         @(posedge clk); #1;
         scramble();
         mif.gnt    = (k == gd);
         mif.rvalid = (k < gd) ? 1'($urandom) : 1'b0;
         mif.rdata  = $urandom;
         @(negedge clk);
         chk("req", mif.req, 1);
         chk("we", mif.we, w);
         chk("addr", mif.addr, a & ~32'd3);
         chk("be", mif.be, m_be(f3, a));
         if (w) chk("wdata", mif.wdata, m_wdata(f3, wd));
         chk("misalign_busy", misalign_o, 0);
         chk("done_busy", done_o, 0);
         chk("stall_req", stall_o, 1);
         if (stall_o) stalls++;
      end
      if (!w) begin
         for (int k = 0; k <= rd; k++) begin
            @(posedge clk); #1;
            scramble();
            mif.gnt    = 1'b0;
            mif.rvalid = (k == rd);
            mif.rdata  = (k == rd) ? word : $urandom;
            @(negedge clk);
            chk("req_wait", mif.req, 0);
            chk("be_wait", mif.be, 0);
            chk("wdata_wait", mif.wdata, 0);
            chk("stall_wait", stall_o, 1);
            if (stall_o) stalls++;
         end
      end
      @(posedge clk); #1;
      scramble();
      mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = $urandom;
      @(negedge clk);
      if (!w) model_rd = m_load(f3, a, word);
      chk("done", done_o, 1);
      chk("stall_done", stall_o, 0);
      chk("req_done", mif.req, 0);
      chk("rdata", rdata_o, model_rd);
      chk("stall_cnt", stalls, w ? 2 + gd : 3 + gd + rd);
      valid_i = 1'b0;
   endtask

   task automatic reset_mid_load();
      @(posedge clk); #1;
      valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h600; wdata_i = '0;
      mif.gnt = 1'b0; mif.rvalid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         valid_i = 1'b0;
         mif.gnt = (k == 5);
         @(negedge clk);
         chk("rst_req_hold", mif.req, 1);
         chk("rst_addr_hold", mif.addr, 32'h600);
      end
      @(posedge clk); #1;
      mif.gnt = 1'b0;
      valid_i = 1'b1;
      @(negedge clk);
      chk("rst_in_wait", stall_o, 1);
      rst = 1'b1;
      #1;
      model_rd = '0;
      chk("rst_req", mif.req, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_mis", misalign_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_rdata", rdata_o, model_rd);
      chk("rst_be", mif.be, 0);
      chk("rst_addr", mif.addr, 0);
      @(posedge clk); #1;
      mif.rvalid = 1'b1; mif.rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      rst = 1'b0; valid_i = 1'b0;
      @(negedge clk);
      chk("late_rvalid_rdata", rdata_o, model_rd);
      chk("late_rvalid_req", mif.req, 0);
      @(posedge clk); #1;
      mif.rvalid = 1'b0;
      @(negedge clk);
      chk("late_rvalid_done", done_o, 0);
      chk("late_rvalid_rdata2", rdata_o, model_rd);
   endtask

   initial begin
      logic [2:0] f3;
      logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = '0;
      valid_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
      @(negedge clk);
      chk("reset_stall", stall_o, 0);
      chk("reset_mis", misalign_o, 0);
      chk("reset_req", mif.req, 0);
      chk("reset_done", done_o, 0);
      chk("reset_rdata", rdata_o, 0);
      chk("reset_wdata", mif.wdata, 0);
      funct3_i = 3'b011;
      #1;
      chk("reset_mis_illegal", misalign_o, 0);
      @(posedge clk); #1;
      valid_i = 1'b0; rst = 1'b0;

      access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      access(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0);
      access(1'b0, 3'b000, 32'h301, 32'h0, 0, 1, 32'h123480FF);
      chk("lb_const", rdata_o, 32'hFFFFFF80);
      access(1'b0, 3'b100, 32'h301, 32'h0, 0, 1, 32'h123480FF);
      chk("lbu_const", rdata_o, 32'h00000080);
      access(1'b0, 3'b001, 32'h402, 32'h0, 0, 0, 32'h80017FFF);
      chk("lh_const", rdata_o, 32'hFFFF8001);
      access(1'b1, 3'b001, 32'h402, 32'h1234ABCD, 2, 0, 0);
      chk("store_keeps_rdata", rdata_o, 32'hFFFF8001);
      access(1'b0, 3'b101, 32'h402, 32'h0, 0, 0, 32'h80017FFF);
      chk("lhu_const", rdata_o, 32'h00008001);
      access(1'b0, 3'b010, 32'h502, 32'h0, 0, 0, 0);
      access(1'b0, 3'b011, 32'h500, 32'h0, 0, 0, 0);
      access(1'b0, 3'b010, 32'h504, 32'h0, 5, 2, 32'h89ABCDEF);
      reset_mid_load();

      for (int i = 0; i < 300; i++) begin
         f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
         access(1'($urandom), f3, $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end
endmodule
